// File: rtl/code83_scan_encoder_pkg.sv
// Shared definitions for the 8-to-3 scan encoder slice: widths and FSM states.
package code83_scan_encoder_pkg;

  localparam int DATAWIDTH_SELECTOR_DEF = 3;
  localparam int DATAWIDTH_DATA_DEF     = 2 ** DATAWIDTH_SELECTOR_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } scan_state_t;

endpackage

// File: rtl/code83_scan_encoder_if.sv
// Load/ack handshake and result bus between occupancy logic and the row-select consumer.
interface code83_scan_encoder_if
  import code83_scan_encoder_pkg::*;
#(
  parameter int DATAWIDTH_SELECTOR = DATAWIDTH_SELECTOR_DEF,
  parameter int DATAWIDTH_DATA     = DATAWIDTH_DATA_DEF
);

  logic [DATAWIDTH_DATA-1:0]     CODE83SCAN_Data_In;
  logic                          CODE83SCAN_Load_In;
  logic                          CODE83SCAN_Ack_In;
  logic [DATAWIDTH_SELECTOR-1:0] CODE83SCAN_Select_Out;
  logic                          CODE83SCAN_Valid_Out;
  logic                          CODE83SCAN_Busy_Out;
  logic                          CODE83SCAN_Done_Out;
  logic [DATAWIDTH_SELECTOR:0]   CODE83SCAN_Count_Out;

  // Requester / consumer side.
  modport master (
    output CODE83SCAN_Data_In, CODE83SCAN_Load_In, CODE83SCAN_Ack_In,
    input  CODE83SCAN_Select_Out, CODE83SCAN_Valid_Out, CODE83SCAN_Busy_Out,
           CODE83SCAN_Done_Out, CODE83SCAN_Count_Out
  );

  // Encoder side.
  modport slave (
    input  CODE83SCAN_Data_In, CODE83SCAN_Load_In, CODE83SCAN_Ack_In,
    output CODE83SCAN_Select_Out, CODE83SCAN_Valid_Out, CODE83SCAN_Busy_Out,
           CODE83SCAN_Done_Out, CODE83SCAN_Count_Out
  );

endinterface

// File: rtl/code38_decoder.sv
// 3-to-8 one-hot row decoder: index 0 selects the MSB, index 7 selects bit 0.
module code38_decoder
  import code83_scan_encoder_pkg::*;
#(
  parameter int DATAWIDTH_SELECTOR = DATAWIDTH_SELECTOR_DEF,
  parameter int DATAWIDTH_DATA     = DATAWIDTH_DATA_DEF
) (
  input  logic [DATAWIDTH_SELECTOR-1:0] sel,
  output logic [DATAWIDTH_DATA-1:0]     onehot
);

  // Shift a single MSB marker right by the index.
  always_comb begin
    onehot = {1'b1, {(DATAWIDTH_DATA-1){1'b0}}} >> sel;
  end

endmodule

// File: rtl/code83_scan_encoder_priority.sv
// Priority encoder with the decoder's mapping: highest set bit yields the lowest index.
module code83_priority
  import code83_scan_encoder_pkg::*;
#(
  parameter int DATAWIDTH_SELECTOR = DATAWIDTH_SELECTOR_DEF,
  parameter int DATAWIDTH_DATA     = DATAWIDTH_DATA_DEF
) (
  input  logic [DATAWIDTH_DATA-1:0]     vec,
  output logic [DATAWIDTH_SELECTOR-1:0] index,
  output logic                          any_set
);

  // Walk upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    index   = '0;
    any_set = |vec;
    for (int i = 0; i < DATAWIDTH_DATA; i++) begin
      if (vec[i]) index = DATAWIDTH_SELECTOR'(DATAWIDTH_DATA - 1 - i);
    end
  end

endmodule

// File: rtl/code83_scan_encoder.sv
// Sequential scan encoder: captures a multi-hot vector and hands out the index
// of every set bit, one per ack, in increasing index order.
module code83_scan_encoder
  import code83_scan_encoder_pkg::*;
#(
  parameter int DATAWIDTH_SELECTOR = DATAWIDTH_SELECTOR_DEF,
  parameter int DATAWIDTH_DATA     = DATAWIDTH_DATA_DEF
) (
  input  logic                 CODE83SCAN_CLOCK_50,
  input  logic                 CODE83SCAN_RESET_InHigh,
  code83_scan_encoder_if.slave bus
);

  localparam int CNT_W = DATAWIDTH_SELECTOR + 1;

  scan_state_t                   state_q, state_d;
  logic [DATAWIDTH_DATA-1:0]     shadow_q, shadow_d;
  logic [DATAWIDTH_SELECTOR-1:0] select_q, select_d;
  logic                          valid_q, valid_d;
  logic                          busy_q, done_q;
  logic [CNT_W-1:0]              count_q, count_d;

  logic [DATAWIDTH_DATA-1:0]     clear_mask;
  logic [DATAWIDTH_DATA-1:0]     remainder;
  logic [DATAWIDTH_DATA-1:0]     scan_vec;
  logic [DATAWIDTH_SELECTOR-1:0] pri_index;
  logic                          pri_any;
  logic [CNT_W-1:0]              popcount;

  // The same decoder the display path uses builds the mask of the presented bit.
  code38_decoder #(
    .DATAWIDTH_SELECTOR(DATAWIDTH_SELECTOR),
    .DATAWIDTH_DATA    (DATAWIDTH_DATA)
  ) u_clear_dec (
    .sel   (select_q),
    .onehot(clear_mask)
  );

  // One priority encoder serves both the first pick (SCAN) and every next pick (PRESENT).
  code83_priority #(
    .DATAWIDTH_SELECTOR(DATAWIDTH_SELECTOR),
    .DATAWIDTH_DATA    (DATAWIDTH_DATA)
  ) u_priority (
    .vec    (scan_vec),
    .index  (pri_index),
    .any_set(pri_any)
  );

  // Operand selection for the priority encoder and popcount of the incoming vector.
  always_comb begin
    remainder = shadow_q & ~clear_mask;
    scan_vec  = (state_q == PRESENT) ? remainder : shadow_q;
    popcount  = '0;
    for (int i = 0; i < DATAWIDTH_DATA; i++) begin
      popcount = popcount + CNT_W'(bus.CODE83SCAN_Data_In[i]);
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    select_d = select_q;
    valid_d  = valid_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.CODE83SCAN_Load_In) begin
          shadow_d = bus.CODE83SCAN_Data_In;
          count_d  = popcount;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (pri_any) begin
          select_d = pri_index;
          valid_d  = 1'b1;
          state_d  = PRESENT;
        end else begin
          state_d = DONE;
        end
      end
      PRESENT: begin
        if (bus.CODE83SCAN_Ack_In) begin
          shadow_d = remainder;
          if (pri_any) begin
            select_d = pri_index;
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything without a Done pulse.
  always_ff @(posedge CODE83SCAN_CLOCK_50) begin
    if (CODE83SCAN_RESET_InHigh) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      select_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      select_q <= select_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
      count_q  <= count_d;
    end
  end

  assign bus.CODE83SCAN_Select_Out = select_q;
  assign bus.CODE83SCAN_Valid_Out  = valid_q;
  assign bus.CODE83SCAN_Busy_Out   = busy_q;
  assign bus.CODE83SCAN_Done_Out   = done_q;
  assign bus.CODE83SCAN_Count_Out  = count_q;

endmodule

// File: tb/tb_code83_scan_encoder.sv
// Bench for code83_scan_encoder: directed scenarios plus a randomized sweep of all
// 256 vectors against a queue-based model of the expected index sequence.
module tb_code83_scan_encoder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  code83_scan_encoder_if bus ();

  code83_scan_encoder dut (
    .CODE83SCAN_CLOCK_50    (clk),
    .CODE83SCAN_RESET_InHigh(rst),
    .bus                    (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one complete load/scan/done transaction and check it against the model.
  task automatic run_scan(input logic [7:0] vec, input int ack_pct, input int stall, input bit noise);
    int         exp_q[$];
    int         pc;
    int         k;
    int         waited;
    int         budget;
    logic [7:0] acc;
    logic [2:0] sel_seen;
    logic       ack;
    pc = 0;
    for (int i = 0; i < 8; i++) begin
      if (vec[7 - i]) begin
        exp_q.push_back(i);
        pc++;
      end
    end
    @(negedge clk);
    bus.CODE83SCAN_Data_In = vec;
    bus.CODE83SCAN_Load_In = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.CODE83SCAN_Load_In = 1'b0;
    check("scan_busy", 32'(bus.CODE83SCAN_Busy_Out), 1);
    check("scan_valid", 32'(bus.CODE83SCAN_Valid_Out), 0);
    check("scan_done", 32'(bus.CODE83SCAN_Done_Out), 0);
    check("count", 32'(bus.CODE83SCAN_Count_Out), pc);
    if (noise) begin
      bus.CODE83SCAN_Load_In = 1'($urandom_range(1));
      bus.CODE83SCAN_Data_In = 8'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
    k = 0;
    waited = 0;
    budget = 0;
    acc = 8'h00;
    if (exp_q.size() == 0) begin
      check("empty_valid", 32'(bus.CODE83SCAN_Valid_Out), 0);
      check("empty_done", 32'(bus.CODE83SCAN_Done_Out), 1);
    end else begin
      while (k < exp_q.size() && budget < 300) begin
        check("valid", 32'(bus.CODE83SCAN_Valid_Out), 1);
        check("select", 32'(bus.CODE83SCAN_Select_Out), exp_q[k]);
        check("done_low", 32'(bus.CODE83SCAN_Done_Out), 0);
        sel_seen = bus.CODE83SCAN_Select_Out;
        if (stall > 0) ack = (waited >= stall);
        else ack = ($urandom_range(99) < ack_pct);
        bus.CODE83SCAN_Ack_In = ack;
        if (noise) begin
          bus.CODE83SCAN_Load_In = 1'($urandom_range(1));
          bus.CODE83SCAN_Data_In = 8'($urandom);
        end
        @(posedge clk);
        @(negedge clk);
        if (ack) begin
          acc = acc | (8'h80 >> sel_seen);
          k++;
          waited = 0;
        end else begin
          waited++;
        end
        budget++;
      end
      bus.CODE83SCAN_Ack_In = 1'b0;
      if (budget >= 300) check("ack_budget", 0, 1);
      check("last_done", 32'(bus.CODE83SCAN_Done_Out), 1);
      check("last_valid", 32'(bus.CODE83SCAN_Valid_Out), 0);
    end
    check("done_busy", 32'(bus.CODE83SCAN_Busy_Out), 1);
    check("count_hold", 32'(bus.CODE83SCAN_Count_Out), pc);
    if (noise) begin
      bus.CODE83SCAN_Load_In = 1'($urandom_range(1));
      bus.CODE83SCAN_Data_In = 8'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
    bus.CODE83SCAN_Load_In = 1'b0;
    check("idle_busy", 32'(bus.CODE83SCAN_Busy_Out), 0);
    check("idle_done", 32'(bus.CODE83SCAN_Done_Out), 0);
    check("idle_valid", 32'(bus.CODE83SCAN_Valid_Out), 0);
    check("idle_count", 32'(bus.CODE83SCAN_Count_Out), pc);
    if (vec != 8'h00) check("roundtrip", 32'(acc), 32'(vec));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.CODE83SCAN_Data_In = 8'h00;
    bus.CODE83SCAN_Load_In = 1'b0;
    bus.CODE83SCAN_Ack_In  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_select", 32'(bus.CODE83SCAN_Select_Out), 0);
    check("rst_valid", 32'(bus.CODE83SCAN_Valid_Out), 0);
    check("rst_busy", 32'(bus.CODE83SCAN_Busy_Out), 0);
    check("rst_done", 32'(bus.CODE83SCAN_Done_Out), 0);
    check("rst_count", 32'(bus.CODE83SCAN_Count_Out), 0);
    rst = 1'b0;

    // Ack held high: back-to-back indices 0, 2, 7.
    run_scan(8'b1010_0001, 100, 0, 1'b0);
    // Empty vector.
    run_scan(8'h00, 100, 0, 1'b0);
    // Five stall cycles before the single ack.
    run_scan(8'b0001_0000, 0, 5, 1'b0);
    // Full vector with loads attempted mid-scan.
    run_scan(8'hFF, 100, 0, 1'b1);

    // Reset while presenting index 0 of 8'b11000000.
    @(negedge clk);
    bus.CODE83SCAN_Data_In = 8'b1100_0000;
    bus.CODE83SCAN_Load_In = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.CODE83SCAN_Load_In = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", 32'(bus.CODE83SCAN_Valid_Out), 1);
    check("pre_rst_select", 32'(bus.CODE83SCAN_Select_Out), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_select", 32'(bus.CODE83SCAN_Select_Out), 0);
    check("mid_rst_valid", 32'(bus.CODE83SCAN_Valid_Out), 0);
    check("mid_rst_busy", 32'(bus.CODE83SCAN_Busy_Out), 0);
    check("mid_rst_done", 32'(bus.CODE83SCAN_Done_Out), 0);
    check("mid_rst_count", 32'(bus.CODE83SCAN_Count_Out), 0);
    @(posedge clk);
    @(negedge clk);
    check("post_rst_done", 32'(bus.CODE83SCAN_Done_Out), 0);
    check("post_rst_busy", 32'(bus.CODE83SCAN_Busy_Out), 0);
    run_scan(8'b0100_0000, 100, 0, 1'b0);

    // Every vector with random backpressure and load noise.
    for (int v = 0; v < 256; v++) begin
      run_scan(8'(v), 30 + int'($urandom_range(70)), 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
